// File: rtl/load_down_counter.sv
// Loadable N-bit down-counter built from T flip-flops with a borrow-chain toggle network.
// Load and decrement land on q one edge after the strobe; zero/bout are combinational.
module load_down_counter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [N-1:0] d,
    input  logic         load,
    input  logic         en,
    output logic [N-1:0] q,
    output logic         zero,
    output logic         bout
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_t;
    logic [N-1:0] w_borrow;
    logic         w_zero;

    // A bit toggles on decrement only when every lower bit is 0 (a borrow ripples through).
    always_comb begin
        w_borrow    = '0;
        w_borrow[0] = en;
        for (int j = 1; j < N; j++) begin
            w_borrow[j] = w_borrow[j-1] & ~r_q[j-1];
        end
    end

    // Loading is expressed as a toggle too: flip exactly the bits that differ from d.
    assign w_t = load ? (d ^ r_q) : w_borrow;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q <= '0;
        end else begin
            r_q <= r_q ^ w_t;
        end
    end

    assign w_zero = (r_q == '0);
    assign q      = r_q;
    assign zero   = w_zero;
    // Gated by nrst so a held-in-reset stage never signals a borrow downstream.
    assign bout   = nrst & en & ~load & w_zero;

endmodule

// File: tb/tb_load_down_counter.sv
// Directed and randomized checks of load_down_counter, including a two-stage cascade.
module tb_load_down_counter;

    logic       clk;
    logic       nrst;
    logic [2:0] d;
    logic       load;
    logic       en;
    logic [2:0] q;
    logic       zero;
    logic       bout;

    logic [2:0] lo_d, hi_d;
    logic       lo_load, hi_load, lo_en;
    logic [2:0] lo_q, hi_q;
    logic       lo_zero, hi_zero, lo_bout, hi_bout;

    int tests;
    int fails;
    logic [2:0] model;
    logic       exp_bout;

    load_down_counter #(.N(3)) u_dut (
        .clk(clk), .nrst(nrst), .d(d), .load(load), .en(en),
        .q(q), .zero(zero), .bout(bout)
    );

    load_down_counter #(.N(3)) u_lo (
        .clk(clk), .nrst(nrst), .d(lo_d), .load(lo_load), .en(lo_en),
        .q(lo_q), .zero(lo_zero), .bout(lo_bout)
    );

    load_down_counter #(.N(3)) u_hi (
        .clk(clk), .nrst(nrst), .d(hi_d), .load(hi_load), .en(lo_bout),
        .q(hi_q), .zero(hi_zero), .bout(hi_bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        nrst    = 1'b0;
        d       = 3'd0;
        load    = 1'b0;
        en      = 1'b0;
        lo_d    = 3'd0;
        hi_d    = 3'd0;
        lo_load = 1'b0;
        hi_load = 1'b0;
        lo_en   = 1'b0;

        // Reset state
        #12;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_bout", 32'(bout), 32'd0);
        nrst = 1'b1;
        tick();

        // 1: asynchronous reset in the middle of a counting cycle
        load = 1'b1; d = 3'd5;
        tick();
        load = 1'b0; en = 1'b1;
        chk("t1_loaded", 32'(q), 32'd5);
        #1 nrst = 1'b0;
        #1;
        chk("t1_async_q", 32'(q), 32'd0);
        chk("t1_async_zero", 32'(zero), 32'd1);
        chk("t1_async_bout", 32'(bout), 32'd0);
        tick();
        chk("t1_held_q", 32'(q), 32'd0);
        nrst = 1'b1; en = 1'b0;
        tick();

        // 2: load 6 then count down through the wrap
        load = 1'b1; d = 3'd6;
        tick();
        chk("t2_load", 32'(q), 32'd6);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk("t2_bout_pre", 32'(bout), (q == 3'd0) ? 32'd1 : 32'd0);
            tick();
            chk("t2_q", 32'(q), 32'((6 - (k + 1)) & 7));
        end
        chk("t2_wrapped", 32'(q), 32'd7);

        // 3: load beats decrement at q=0
        load = 1'b1; en = 1'b0; d = 3'd0;
        tick();
        chk("t3_zero_load_q", 32'(q), 32'd0);
        chk("t3_zero_load_z", 32'(zero), 32'd1);
        load = 1'b1; en = 1'b1; d = 3'd3;
        #1;
        chk("t3_bout", 32'(bout), 32'd0);
        tick();
        chk("t3_q", 32'(q), 32'd3);

        // 4: hold with en=0
        load = 1'b1; en = 1'b0; d = 3'd4;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_q", 32'(q), 32'd4);
            chk("t4_hold_zero", 32'(zero), 32'd0);
        end

        // 5: two cascaded stages form a 6-bit counter
        lo_load = 1'b1; hi_load = 1'b1; lo_d = 3'd0; hi_d = 3'd2;
        tick();
        lo_load = 1'b0; hi_load = 1'b0;
        chk("t5_init_lo", 32'(lo_q), 32'd0);
        chk("t5_init_hi", 32'(hi_q), 32'd2);
        lo_en = 1'b1;
        #1;
        chk("t5_bout_lo", 32'(lo_bout), 32'd1);
        tick();
        chk("t5_step_lo", 32'(lo_q), 32'd7);
        chk("t5_step_hi", 32'(hi_q), 32'd1);
        for (int k = 0; k < 8; k++) tick();
        chk("t5_end_lo", 32'(lo_q), 32'd7);
        chk("t5_end_hi", 32'(hi_q), 32'd0);
        lo_en = 1'b0;

        // 6: random load/en/nrst against a reference model
        model = q;
        for (int i = 0; i < 1000; i++) begin
            load = 1'($urandom_range(0, 1));
            en   = 1'($urandom_range(0, 1));
            d    = 3'($urandom_range(0, 7));
            nrst = ($urandom_range(0, 19) != 0);
            #1;
            if (!nrst) model = 3'd0;
            exp_bout = nrst & en & ~load & (model == 3'd0);
            chk("t6_pre_q", 32'(q), 32'(model));
            chk("t6_zero", 32'(zero), (model == 3'd0) ? 32'd1 : 32'd0);
            chk("t6_bout", 32'(bout), 32'(exp_bout));
            tick();
            if (nrst) model = load ? d : (en ? model - 3'd1 : model);
            else      model = 3'd0;
            chk("t6_q", 32'(q), 32'(model));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog q=%0d expected=finish", q);
        $fatal(1, "timeout");
    end

endmodule
